// File: rtl/gpio_pkg.sv
// gpio_pkg: register map and edge-mode encoding shared by the gpio_expansion_port files.
package gpio_pkg;
  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_DIR  = 3'd1;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;
  localparam logic [2:0] ADDR_SET  = 3'd4;
  localparam logic [2:0] ADDR_CLR  = 3'd5;
  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_t;
endpackage

// File: rtl/gpio_expansion_port_debounce.sv
// gpio_debounce: single-channel debouncer; the stable value follows the input once it
// has differed for CYCLES consecutive clocks.
module gpio_debounce #(
  parameter int CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);
  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (raw == stable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt    <= '0;
      stable <= raw;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/gpio_expansion_port.sv
// gpio_expansion_port: Avalon-MM parallel port with per-bit direction, set/clear writes,
// edge capture and maskable irq; define GPIO_DEBOUNCE_EN to debounce every input.
module gpio_expansion_port
  import gpio_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int EDGE_MODE       = 0,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [3:0]       byteenable,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  inout  wire  [WIDTH-1:0] gpio
);
  localparam edge_mode_t MODE = edge_mode_t'(EDGE_MODE);
  logic [WIDTH-1:0] data_out, direction, irqmask, edgecapture;
  logic [WIDTH-1:0] sync1, sync2, cond_in, cond_prev;
  logic [WIDTH-1:0] bm, wd, rise, fall, edges, clr, rd_sel;
  logic [WIDTH-1:0] data_nx, dir_nx, mask_nx, edge_nx;
  logic [31:0] lane;
  logic wr_en, unused_ok;
  assign lane      = {{8{byteenable[3]}}, {8{byteenable[2]}}, {8{byteenable[1]}}, {8{byteenable[0]}}};
  assign bm        = lane[WIDTH-1:0];
  assign wd        = writedata[WIDTH-1:0] & bm;
  assign wr_en     = chipselect & write;
  assign unused_ok = ^{writedata, lane, 32'(DEBOUNCE_CYCLES)};
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign gpio[i] = direction[i] ? data_out[i] : 1'bz;
  end
`ifdef GPIO_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    gpio_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .reset  (reset),
      .raw    (sync2[i]),
      .stable (cond_in[i])
    );
  end
`else
  assign cond_in = sync2;
`endif
  assign rise  = cond_in & ~cond_prev;
  assign fall  = ~cond_in & cond_prev;
  assign edges = MODE == EDGE_BOTH ? rise | fall : MODE == EDGE_FALL ? fall : rise;
  always_comb begin
    data_nx = !wr_en ? data_out
            : address == ADDR_DATA ? (data_out & ~bm) | wd
            : address == ADDR_SET  ? data_out | wd
            : address == ADDR_CLR  ? data_out & ~wd
            : data_out;
    dir_nx  = wr_en && address == ADDR_DIR  ? (direction & ~bm) | wd : direction;
    mask_nx = wr_en && address == ADDR_MASK ? (irqmask & ~bm) | wd : irqmask;
    clr     = wr_en && address == ADDR_EDGE ? wd : '0;
    // a new edge outranks a clear landing on the same bit
    edge_nx = (edgecapture & ~clr) | edges;
    rd_sel  = address == ADDR_DATA ? cond_in
            : address == ADDR_DIR  ? direction
            : address == ADDR_MASK ? irqmask
            : address == ADDR_EDGE ? edgecapture
            : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out    <= '0;
      direction   <= '0;
      irqmask     <= '0;
      edgecapture <= '0;
      sync1       <= '0;
      sync2       <= '0;
      cond_prev   <= '0;
      readdata    <= '0;
      irq         <= 1'b0;
    end else begin
      data_out    <= data_nx;
      direction   <= dir_nx;
      irqmask     <= mask_nx;
      edgecapture <= edge_nx;
      sync1       <= gpio;
      sync2       <= sync1;
      cond_prev   <= cond_in;
      irq         <= |(edgecapture & irqmask);
      if (chipselect && read) readdata <= 32'(rd_sel);
    end
  end
endmodule

// File: tb/tb_gpio_expansion_port.sv
// tb_gpio_expansion_port: directed checks of an 8-bit rising-edge port (pulldowns) and a
// 5-bit both-edge port (pullups); latencies follow GPIO_DEBOUNCE_EN with DEBOUNCE_CYCLES=4.
module tb_gpio_expansion_port;
  import gpio_pkg::*;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic [2:0] address = '0;
  logic read = 1'b0, write = 1'b0, cs8 = 1'b0, cs5 = 1'b0;
  logic [3:0] byteenable = '0;
  logic [31:0] writedata = '0, rd8, rd5;
  logic irq8, irq5;
  logic [7:0] pd8 = '0, pe8 = '0;
  logic [4:0] pd5 = '0, pe5 = '0;
  wire [7:0] g8;
  wire [4:0] g5;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  for (genvar i = 0; i < 8; i++) begin : g_p8
    assign g8[i] = pe8[i] ? pd8[i] : 1'bz;
    pulldown (g8[i]);
  end
  for (genvar i = 0; i < 5; i++) begin : g_p5
    assign g5[i] = pe5[i] ? pd5[i] : 1'bz;
    pullup (g5[i]);
  end
  gpio_expansion_port #(.WIDTH(8), .EDGE_MODE(0), .DEBOUNCE_CYCLES(4)) u8 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs8), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .readdata(rd8), .irq(irq8), .gpio(g8)
  );
  gpio_expansion_port #(.WIDTH(5), .EDGE_MODE(2), .DEBOUNCE_CYCLES(4)) u5 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs5), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .readdata(rd5), .irq(irq5), .gpio(g5)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input bit sel5, input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    cs8 = !sel5; cs5 = sel5; write = 1'b1; address = a; writedata = d; byteenable = be;
    @(negedge clk);
    cs8 = 1'b0; cs5 = 1'b0; write = 1'b0;
  endtask
  task automatic rchk(input bit sel5, input logic [2:0] a, input logic [31:0] exp, input string tag);
    cs8 = !sel5; cs5 = sel5; read = 1'b1; address = a;
    @(negedge clk);
    cs8 = 1'b0; cs5 = 1'b0; read = 1'b0;
    chk(tag, sel5 ? rd5 : rd8, exp);
  endtask
  initial begin
    cyc(3);
    reset = 1'b0;
    chk("irq8_reset", irq8, 0);
    chk("irq5_reset", irq5, 0);
    chk("pins8_undriven", g8, 8'h00);
    chk("pins5_undriven", g5, 5'h1F);
    for (int a = 0; a < 8; a++) rchk(0, 3'(a), 0, $sformatf("reg%0d_reset", a));
    // output path on the 8-bit port
    wr(0, ADDR_DIR, 32'hFF, 4'hF);
    wr(0, ADDR_DATA, 32'h5A, 4'hF);
    wr(0, ADDR_SET, 32'h81, 4'hF);
    chk("pins_after_set", g8, 8'hDB);
    wr(0, ADDR_CLR, 32'h02, 4'hF);
    chk("pins_after_clr", g8, 8'hD9);
    cyc(LAT + 1);
    rchk(0, ADDR_DATA, 32'hD9, "data_readback");
    wr(0, ADDR_DATA, 32'h00, 4'h0);
    chk("be0_ignored", g8, 8'hD9);
    wr(0, ADDR_CLR, 32'hFF, 4'h2);
    chk("be_lane1_clr_ignored", g8, 8'hD9);
    wr(0, ADDR_DATA, 32'h3C, 4'h1);
    chk("be_lane0_write", g8, 8'h3C);
    // input path and rising-edge capture
    wr(0, ADDR_DIR, 32'h00, 4'hF);
    pe8 = 8'hFF; pd8 = 8'h00;
    cyc(LAT + 2);
    wr(0, ADDR_EDGE, 32'hFF, 4'hF);
    rchk(0, ADDR_EDGE, 0, "edge_cleared");
    wr(0, ADDR_MASK, 32'h01, 4'hF);
    pd8[0] = 1'b1;
    cyc(LAT + 1);
    chk("irq_not_yet", irq8, 0);
    cyc(1);
    chk("irq_set", irq8, 1);
    rchk(0, ADDR_EDGE, 32'h01, "edge0_captured");
    wr(0, ADDR_EDGE, 32'h01, 4'hF);
    chk("irq_held_one_cycle", irq8, 1);
    cyc(1);
    chk("irq_cleared", irq8, 0);
    rchk(0, ADDR_EDGE, 0, "edge0_cleared");
    pd8[0] = 1'b0;
    cyc(LAT + 2);
    rchk(0, ADDR_EDGE, 0, "falling_ignored");
    pd8[0] = 1'b1;
    cyc(LAT + 2);
    wr(0, ADDR_EDGE, 32'h01, 4'hF);
    // clear and new edge on bit 3 at the same clock edge
    pd8[3] = 1'b1;
    cyc(LAT);
    wr(0, ADDR_EDGE, 32'h08, 4'hF);
    rchk(0, ADDR_EDGE, 32'h08, "edge_beats_clear");
    chk("irq_masked_bit3", irq8, 0);
    wr(0, ADDR_EDGE, 32'h08, 4'hF);
    rchk(0, ADDR_EDGE, 0, "bit3_cleared");
    rchk(0, ADDR_DATA, 32'h09, "data_inputs");
`ifdef GPIO_DEBOUNCE_EN
    pd8[2] = 1'b1;
    cyc(3);
    pd8[2] = 1'b0;
    cyc(8);
    rchk(0, ADDR_DATA, 32'h09, "glitch_filtered");
    rchk(0, ADDR_EDGE, 0, "glitch_no_capture");
    pd8[2] = 1'b1;
    cyc(5);
    rchk(0, ADDR_DATA, 32'h09, "pulse_before_accept");
    rchk(0, ADDR_DATA, 32'h0D, "pulse_accepted");
`else
    pd8[2] = 1'b1;
    cyc(1);
    rchk(0, ADDR_DATA, 32'h09, "sync_before");
    rchk(0, ADDR_DATA, 32'h0D, "sync_after");
`endif
    pd8[2] = 1'b0;
    cyc(LAT + 2);
    wr(0, ADDR_EDGE, 32'hFF, 4'hF);
    // 5-bit port: width masking and both-edge capture
    wr(1, ADDR_DIR, 32'hFFFFFFFF, 4'hF);
    rchk(1, ADDR_DIR, 32'h1F, "w5_dir");
    wr(1, ADDR_MASK, 32'hFFFFFFFF, 4'hF);
    rchk(1, ADDR_MASK, 32'h1F, "w5_mask");
    wr(1, ADDR_DATA, 32'hFFFFFFF0, 4'hF);
    chk("w5_pins", g5, 5'h10);
    cyc(LAT);
    rchk(1, ADDR_DATA, 32'h10, "w5_data_10");
    wr(1, ADDR_DATA, 32'hFFFFFFFF, 4'hF);
    cyc(LAT);
    rchk(1, ADDR_DATA, 32'h1F, "w5_data_1f");
    wr(1, ADDR_DIR, 32'h0, 4'hF);
    wr(1, ADDR_EDGE, 32'hFFFFFFFF, 4'hF);
    cyc(LAT + 2);
    rchk(1, ADDR_EDGE, 0, "w5_edge_clear");
    chk("w5_irq_clear", irq5, 0);
    pe5[1] = 1'b1; pd5[1] = 1'b0;
    cyc(LAT + 3);
    rchk(1, ADDR_EDGE, 32'h02, "w5_fall_captured");
    chk("w5_irq_set", irq5, 1);
    wr(1, ADDR_EDGE, 32'h02, 4'hF);
    pe5[1] = 1'b0;
    cyc(LAT + 3);
    rchk(1, ADDR_EDGE, 32'h02, "w5_rise_captured");
    // reset in the middle of operation
    rchk(0, ADDR_DATA, 32'h09, "pre_reset_read");
    reset = 1'b1;
    cyc(1);
    chk("readdata_reset", rd8, 0);
    chk("irq5_reset_mid", irq5, 0);
    reset = 1'b0;
    rchk(0, ADDR_DIR, 0, "dir_after_reset");
    rchk(1, ADDR_MASK, 0, "mask_after_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
